trace_serialiser: RTL and testbench



---
 rtl/trace_pkg.sv | 14 +
 rtl/trace_beat_shifter.sv | 55 +++++
 rtl/trace_serialiser.sv | 97 +++++++++
 tb/tb_trace_serialiser.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared types, defaults and beat-count helper for the trace serialiser.
// Contents: trace_ser_state_t FSM encoding, TRACE_ELEMENT_WIDTH default, beats_for().
// Macro TRACE_SERIALISER_HEADER_EN adds one header beat per element to beats_for().
package trace_pkg;
  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, SEND} trace_ser_state_t;
  localparam int TRACE_ELEMENT_WIDTH = 64;
  function automatic int beats_for(input int element_width, input int out_width);
`ifdef TRACE_SERIALISER_HEADER_EN
    return element_width / out_width + 1;
`else
    return element_width / out_width;
`endif
  endfunction
endpackage

// File: rtl/trace_beat_shifter.sv
// trace_beat_shifter: capture register and beat index that slice one element into beats.
// Ports: clk, rst_n (async active-low), load (capture element, restart at beat 0),
//        advance (step to next beat), element, seq (header sequence number, only with
//        TRACE_SERIALISER_HEADER_EN), out_data (current beat), out_last (final beat).
// Macro TRACE_SERIALISER_HEADER_EN: beat 0 carries seq and the element starts at beat 1.
module trace_beat_shifter import trace_pkg::*; #(
  parameter int ELEMENT_WIDTH = TRACE_ELEMENT_WIDTH,
  parameter int OUT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     advance,
  input  logic [ELEMENT_WIDTH-1:0] element,
`ifdef TRACE_SERIALISER_HEADER_EN
  input  logic [15:0]              seq,
`endif
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_last
);
  localparam int BEATS = beats_for(ELEMENT_WIDTH, OUT_WIDTH);
  localparam int IW    = $clog2(BEATS + 1);
  logic [ELEMENT_WIDTH-1:0] cap_q, cap_d;
  logic [IW-1:0]            idx_q, idx_d;
  assign out_last = idx_q == IW'(BEATS - 1);
`ifdef TRACE_SERIALISER_HEADER_EN
  assign out_data = (idx_q == '0) ? OUT_WIDTH'(seq) : cap_q[OUT_WIDTH-1:0];
`else
  assign out_data = cap_q[OUT_WIDTH-1:0];
`endif
  // The low slice is always the current beat, so advancing shifts the element down.
  always_comb begin
    cap_d = cap_q;
    idx_d = idx_q;
    if (load) begin
      cap_d = element;
      idx_d = '0;
    end else if (advance) begin
      idx_d = out_last ? '0 : idx_q + IW'(1);
`ifdef TRACE_SERIALISER_HEADER_EN
      if (idx_q != '0) cap_d = cap_q >> OUT_WIDTH;
`else
      cap_d = cap_q >> OUT_WIDTH;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cap_q <= '0;
      idx_q <= '0;
    end else begin
      cap_q <= cap_d;
      idx_q <= idx_d;
    end
endmodule

// File: rtl/trace_serialiser.sv
// trace_serialiser: drains trace elements from the buffer and streams them as beats.
// Ports: clk, rst_n (async active-low), data_present/data_request (buffer pop interface,
//        element valid REQ_LATENCY cycles after the pop), trace_element_in,
//        out_valid/out_ready/out_data/out_last (beat stream, LSB beat first),
//        elements_sent (wrapping count of fully transmitted elements).
// Macro TRACE_SERIALISER_HEADER_EN: each element is preceded by a sequence-number beat.
module trace_serialiser import trace_pkg::*; #(
  parameter int ELEMENT_WIDTH = TRACE_ELEMENT_WIDTH,
  parameter int OUT_WIDTH     = 16,
  parameter int REQ_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_present,
  input  logic [ELEMENT_WIDTH-1:0] trace_element_in,
  output logic                     data_request,
  output logic                     out_valid,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [31:0]              elements_sent
);
  trace_ser_state_t state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic        req_q, req_d;
  logic [31:0] cnt_q, cnt_d;
  logic        load, advance, done, beat_last;
  logic [OUT_WIDTH-1:0] beat_data;
`ifdef TRACE_SERIALISER_HEADER_EN
  logic [15:0] seq_q, seq_d;
`endif
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE:    state_d = data_present ? REQUEST : IDLE;
      REQUEST: begin
        state_d = WAIT;
        lat_d   = 3'(REQ_LATENCY);
      end
      WAIT: begin
        lat_d   = lat_q - 3'd1;
        load    = lat_q == 3'd1;
        state_d = load ? SEND : WAIT;
      end
      SEND: begin
        advance = out_ready;
        if (out_ready && beat_last) state_d = data_present ? REQUEST : IDLE;
      end
      default: state_d = IDLE;
    endcase
    done  = advance & beat_last;
    cnt_d = cnt_q + 32'(done);
    // Registering the pop strobe from the next state keeps it glitch-free at the buffer.
    req_d = state_d == REQUEST;
`ifdef TRACE_SERIALISER_HEADER_EN
    seq_d = seq_q + 16'(done);
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef TRACE_SERIALISER_HEADER_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
`ifdef TRACE_SERIALISER_HEADER_EN
      seq_q   <= seq_d;
`endif
    end
  trace_beat_shifter #(.ELEMENT_WIDTH(ELEMENT_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (advance),
    .element (trace_element_in),
`ifdef TRACE_SERIALISER_HEADER_EN
    .seq     (seq_q),
`endif
    .out_data(beat_data),
    .out_last(beat_last)
  );
  assign data_request  = req_q;
  assign out_valid     = state_q == SEND;
  assign out_data      = out_valid ? beat_data : '0;
  assign out_last      = out_valid & beat_last;
  assign elements_sent = cnt_q;
endmodule

// File: tb/tb_trace_serialiser.sv
// tb_trace_serialiser: self-checking bench for trace_serialiser against a beat-queue model.
module tb_trace_serialiser;
  localparam int EW = 64;
  localparam int OW = 16;
  localparam int L  = 1;
  localparam int NB = EW / OW;
`ifdef TRACE_SERIALISER_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif
  typedef struct { logic [OW-1:0] d; bit l; } beat_t;
  logic          clk, rst_n, data_present, data_request, out_valid, out_last, out_ready;
  logic [EW-1:0] trace_element_in;
  logic [OW-1:0] out_data;
  logic [31:0]   elements_sent;
  trace_serialiser #(.ELEMENT_WIDTH(EW), .OUT_WIDTH(OW), .REQ_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .data_present(data_present), .trace_element_in(trace_element_in),
    .data_request(data_request), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .elements_sent(elements_sent)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc_n = 0, req_c = 0, cd = 0, xfers = 0, reqs = 0, seq_m = 0;
  bit en, rdy, busy, prev_present, prev_busy, prev_last, prev_stall;
  logic [OW-1:0] prev_data;
  logic          prev_lastv;
  logic [EW-1:0] pv;
  logic [31:0]   exp_sent;
  logic [EW-1:0] buf_q[$];
  beat_t         exp_q[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_beats(input logic [EW-1:0] e);
    beat_t b;
`ifdef TRACE_SERIALISER_HEADER_EN
    b.d = OW'(16'(seq_m));
    b.l = 1'b0;
    exp_q.push_back(b);
    seq_m++;
`endif
    for (int k = 0; k < NB; k++) begin
      b.d = e[k*OW +: OW];
      b.l = (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask
  task automatic cyc();
    bit hit, lx;
    beat_t b;
    @(negedge clk);
    cyc_n++;
    chk("data_request", data_request, prev_present && (!prev_busy || prev_last));
    if (data_request) begin
      reqs++;
      busy = 1;
      req_c = cyc_n;
      cd = L;
      if (buf_q.size() > 0) begin
        pv = buf_q.pop_front();
        push_beats(pv);
      end
    end
    chk("out_valid", out_valid, busy && (cyc_n >= req_c + L + 1));
    chk("elements_sent", elements_sent, exp_sent);
    if (prev_stall) begin
      chk("hold_data", out_data, prev_data);
      chk("hold_last", out_last, prev_lastv);
    end
    hit = 0;
    if (!data_request && cd > 0) begin
      cd--;
      hit = (cd == 0);
    end
    trace_element_in = hit ? pv : {$urandom, $urandom};
    out_ready = rdy;
    data_present = en && buf_q.size() > 0;
    lx = 0;
    if (out_valid && out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_beat: observed data %0h with no beat expected", out_data);
      end else begin
        b = exp_q.pop_front();
        chk("beat_data", out_data, b.d);
        chk("beat_last", out_last, b.l);
        if (b.l) begin
          exp_sent++;
          lx = 1;
        end
      end
    end
    prev_busy = busy;
    if (lx) busy = 0;
    prev_last = lx;
    prev_present = data_present;
    prev_stall = out_valid && !out_ready;
    prev_data = out_data;
    prev_lastv = out_last;
  endtask
  task automatic model_reset();
    exp_q.delete();
    busy = 0; prev_busy = 0; prev_last = 0; prev_stall = 0;
    cd = 0; exp_sent = 0; seq_m = 0;
    data_present = en && buf_q.size() > 0;
  endtask
  task automatic reset_check(input string tag);
    chk({tag, "_request"}, data_request, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_sent"}, elements_sent, 0);
  endtask
  task automatic drain(input int budget);
    int t = 0;
    while (((en && buf_q.size() > 0) || busy || exp_q.size() > 0) && t < budget) begin
      cyc();
      t++;
    end
    if (busy || exp_q.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed %0d beats pending, expected 0", exp_q.size());
    end
    repeat (3) cyc();
  endtask
  task automatic wait_xfers(input int n, input int budget);
    int t = 0;
    while (xfers < n && t < budget) begin
      cyc();
      t++;
    end
    if (xfers < n) begin
      checks++;
      errors++;
      $error("FAIL xfer_timeout: observed %0d transfers, expected %0d", xfers, n);
    end
  endtask
  initial begin
    int x0, r0;
    rst_n = 0; en = 1; rdy = 1; out_ready = 1; trace_element_in = '0;
    buf_q.push_back(64'h1122334455667788);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      reset_check("reset");
    end
    rst_n = 1;
    prev_present = data_present;
    drain(50);
    chk("single_sent", elements_sent, 1);
    buf_q.push_back(64'h1122334455667788);
    data_present = en;
    prev_present = data_present;
    x0 = xfers;
    wait_xfers(x0 + H + 1, 50);
    rdy = 0;
    repeat (3) begin
      cyc();
      chk("stall_data", out_data, 16'h5566);
      chk("stall_valid", out_valid, 1);
    end
    rdy = 1;
    drain(50);
    chk("stall_sent", elements_sent, 2);
    r0 = reqs;
    buf_q.push_back(64'hA5A5_0F0F_DEAD_BEEF);
    buf_q.push_back(64'h0123_4567_89AB_CDEF);
    data_present = en;
    prev_present = data_present;
    drain(80);
    chk("b2b_requests", reqs - r0, 2);
    chk("b2b_sent", elements_sent, 4);
    repeat (12) buf_q.push_back({$urandom, $urandom});
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom % 4) != 0;
      en = ($urandom % 8) != 0;
      cyc();
    end
    en = 1; rdy = 1;
    drain(400);
    chk("random_sent", elements_sent, 16);
    buf_q.push_back(64'hCAFE_F00D_1234_5678);
    data_present = en;
    prev_present = data_present;
    x0 = xfers;
    wait_xfers(x0 + H + 2, 50);
    #2 rst_n = 0;
    #1 reset_check("async_reset");
    buf_q.delete();
    en = 0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      reset_check("in_reset");
    end
    rst_n = 1;
    prev_present = data_present;
    repeat (10) cyc();
    chk("post_reset_sent", elements_sent, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
